// File: rtl/adjacency_loader.sv
// Turns "src: dst dst\n" text into dense node indices plus a CSR-style store
// (per-node offset/degree, flat edge list) and serves 2-cycle successor lookups.
module adjacency_loader #(
    parameter int NODE_IDX_WIDTH  = 10,
    parameter int COUNTER_WIDTH   = 5,
    parameter int EDGE_ADDR_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [7:0]                in_byte,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic                      load_done,
    output logic                      load_error,
    output logic [NODE_IDX_WIDTH:0]   node_count,
    output logic [NODE_IDX_WIDTH-1:0] you_idx,
    output logic [NODE_IDX_WIDTH-1:0] out_idx,
    output logic [NODE_IDX_WIDTH-1:0] svr_idx,
    output logic [NODE_IDX_WIDTH-1:0] dac_idx,
    output logic [NODE_IDX_WIDTH-1:0] fft_idx,
    output logic [4:0]                special_vld,
    input  logic                      rd_en,
    input  logic [NODE_IDX_WIDTH-1:0] rd_node_idx,
    input  logic [COUNTER_WIDTH-1:0]  rd_succ_sel,
    output logic                      rd_valid,
    output logic [NODE_IDX_WIDTH-1:0] rd_next_idx,
    output logic [COUNTER_WIDTH-1:0]  rd_degree
);
    localparam int NW     = NODE_IDX_WIDTH;
    localparam int CW     = COUNTER_WIDTH;
    localparam int EW     = EDGE_ADDR_WIDTH;
    localparam int KEY_W  = 15;
    localparam int STAGES = 2;

    localparam logic [KEY_W-1:0] KEY_YOU = {5'd24, 5'd14, 5'd20};
    localparam logic [KEY_W-1:0] KEY_OUT = {5'd14, 5'd20, 5'd19};
    localparam logic [KEY_W-1:0] KEY_SVR = {5'd18, 5'd21, 5'd17};
    localparam logic [KEY_W-1:0] KEY_DAC = {5'd3,  5'd0,  5'd2};
    localparam logic [KEY_W-1:0] KEY_FFT = {5'd5,  5'd5,  5'd19};

    typedef enum logic [3:0] {
        S_IDLE, S_SRC, S_LOOKUP, S_WRITE, S_COLON, S_SEP, S_DST, S_FINAL, S_DONE, S_ERROR
    } state_t;

    state_t state, state_nxt;

    logic [NW-1:0]    name_map   [0:(1<<KEY_W)-1];
    logic [KEY_W-1:0] rev_name   [0:(1<<NW)-1];
    logic [EW-1:0]    offset_mem [0:(1<<NW)-1];
    logic [CW-1:0]    degree_mem [0:(1<<NW)-1];
    logic [NW-1:0]    edge_mem   [0:(1<<EW)-1];

    logic [KEY_W-1:0] key_q;
    logic [1:0]       nchar;
    logic             is_dst, last_q;
    logic [NW-1:0]    cand_q, src_q;
    logic [EW-1:0]    line_start;
    logic [CW-1:0]    cnt;
    logic [EW:0]      edge_ptr;

    logic       accept, is_letter, is_nl, is_sp, is_colon;
    logic [4:0] ch;
    logic       hit, need_alloc, alloc_ovf, dst_ovf, wr_err, alloc, edge_wr;
    logic [NW-1:0] res_idx;

    assign accept    = in_valid && in_ready;
    assign is_letter = (in_byte >= 8'h61) && (in_byte <= 8'h7a);
    assign is_nl     = (in_byte == 8'h0a);
    assign is_sp     = (in_byte == 8'h20);
    assign is_colon  = (in_byte == 8'h3a);
    assign ch        = in_byte[4:0] - 5'd1;

    // name_map is never cleared: a candidate only counts if the reverse table agrees.
    assign hit        = ({1'b0, cand_q} < node_count) && (rev_name[cand_q] == key_q);
    assign res_idx    = hit ? cand_q : node_count[NW-1:0];
    assign need_alloc = (state == S_WRITE) && !hit;
    assign alloc_ovf  = need_alloc && node_count[NW];
    assign dst_ovf    = (state == S_WRITE) && is_dst && ((cnt == '1) || edge_ptr[EW]);
    assign wr_err     = alloc_ovf || dst_ovf;
    assign alloc      = need_alloc && !wr_err;
    assign edge_wr    = (state == S_WRITE) && is_dst && !wr_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_SRC;
            S_SRC, S_DST: begin
                if (accept) begin
                    if (is_letter) begin
                        if (nchar == 2'd2)  state_nxt = S_LOOKUP;
                        else if (in_last)   state_nxt = S_ERROR;
                    end else if (state == S_SRC && is_nl && nchar == 2'd0) begin
                        state_nxt = in_last ? S_DONE : S_SRC;
                    end else begin
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_LOOKUP: state_nxt = S_WRITE;
            S_WRITE: begin
                if (wr_err)      state_nxt = S_ERROR;
                else if (last_q) state_nxt = S_FINAL;
                else             state_nxt = is_dst ? S_SEP : S_COLON;
            end
            S_COLON: if (accept) state_nxt = !is_colon ? S_ERROR : (in_last ? S_FINAL : S_SEP);
            S_SEP: begin
                if (accept) begin
                    if (is_nl || (is_sp && in_last)) state_nxt = S_FINAL;
                    else if (is_sp)                  state_nxt = S_DST;
                    else                             state_nxt = S_ERROR;
                end
            end
            S_FINAL: state_nxt = last_q ? S_DONE : S_SRC;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        in_ready   = (state == S_SRC) || (state == S_COLON) || (state == S_SEP) ||
                     (state == S_DST) || (state == S_ERROR);
        load_done  = (state == S_DONE);
        load_error = (state == S_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q       <= '0;
            nchar       <= '0;
            is_dst      <= 1'b0;
            last_q      <= 1'b0;
            cand_q      <= '0;
            src_q       <= '0;
            line_start  <= '0;
            cnt         <= '0;
            edge_ptr    <= '0;
            node_count  <= '0;
            you_idx     <= '0;
            out_idx     <= '0;
            svr_idx     <= '0;
            dac_idx     <= '0;
            fft_idx     <= '0;
            special_vld <= '0;
        end else begin
            if (accept && in_last) last_q <= 1'b1;
            if (accept && is_letter && (state == S_SRC || state == S_DST)) begin
                key_q  <= {key_q[KEY_W-6:0], ch};
                nchar  <= (nchar == 2'd2) ? 2'd0 : nchar + 2'd1;
                is_dst <= (state == S_DST);
            end
            if (state == S_LOOKUP) cand_q <= name_map[key_q];
            if (state == S_WRITE && !wr_err) begin
                if (!is_dst) begin
                    src_q      <= res_idx;
                    line_start <= edge_ptr[EW-1:0];
                    cnt        <= '0;
                end else begin
                    edge_ptr <= edge_ptr + (EW+1)'(1);
                    cnt      <= cnt + CW'(1);
                end
            end
            if (alloc) begin
                node_count <= node_count + (NW+1)'(1);
                if (key_q == KEY_YOU) begin you_idx <= node_count[NW-1:0]; special_vld[0] <= 1'b1; end
                if (key_q == KEY_OUT) begin out_idx <= node_count[NW-1:0]; special_vld[1] <= 1'b1; end
                if (key_q == KEY_SVR) begin svr_idx <= node_count[NW-1:0]; special_vld[2] <= 1'b1; end
                if (key_q == KEY_DAC) begin dac_idx <= node_count[NW-1:0]; special_vld[3] <= 1'b1; end
                if (key_q == KEY_FFT) begin fft_idx <= node_count[NW-1:0]; special_vld[4] <= 1'b1; end
            end
        end
    end

    // Table storage carries no reset; validity is tracked by node_count alone.
    always_ff @(posedge clk) begin
        if (alloc) begin
            name_map[key_q]                <= node_count[NW-1:0];
            rev_name[node_count[NW-1:0]]   <= key_q;
            degree_mem[node_count[NW-1:0]] <= '0;
        end else if (state == S_FINAL) begin
            degree_mem[src_q] <= cnt;
        end
        if (state == S_FINAL) offset_mem[src_q] <= line_start;
        if (edge_wr) edge_mem[edge_ptr[EW-1:0]] <= res_idx;
    end

    logic [STAGES-1:0] vld_pipe;
    logic [EW-1:0]     s1_off;
    logic [CW-1:0]     s1_deg, s1_sel;
    logic              rd_req;

    assign rd_req   = rd_en && load_done;
    assign rd_valid = vld_pipe[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe    <= '0;
            s1_off      <= '0;
            s1_deg      <= '0;
            s1_sel      <= '0;
            rd_next_idx <= '0;
            rd_degree   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], rd_req};
            if (rd_req) begin
                s1_off <= offset_mem[rd_node_idx];
                s1_deg <= degree_mem[rd_node_idx];
                s1_sel <= rd_succ_sel;
            end
            if (vld_pipe[0]) begin
                rd_next_idx <= (s1_sel < s1_deg) ? edge_mem[s1_off + EW'(s1_sel)] : '0;
                rd_degree   <= s1_deg;
            end
        end
    end
endmodule

// File: tb/tb_adjacency_loader.sv
// Directed + randomized bench for adjacency_loader; expected tables come from a
// string-level parse of the same text (name dictionary + per-source successor lists).
module tb_adjacency_loader;
    localparam int NW = 10, CW = 5, EW = 13;

    logic clk = 1'b0, rst;
    logic in_valid, in_last, in_ready, load_done, load_error, rd_en, rd_valid;
    logic [7:0] in_byte;
    logic [NW:0] node_count;
    logic [NW-1:0] you_idx, out_idx, svr_idx, dac_idx, fft_idx, rd_node_idx, rd_next_idx;
    logic [4:0] special_vld;
    logic [CW-1:0] rd_succ_sel, rd_degree;

    adjacency_loader #(.NODE_IDX_WIDTH(NW), .COUNTER_WIDTH(CW), .EDGE_ADDR_WIDTH(EW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
        .in_ready(in_ready), .load_done(load_done), .load_error(load_error),
        .node_count(node_count), .you_idx(you_idx), .out_idx(out_idx), .svr_idx(svr_idx),
        .dac_idx(dac_idx), .fft_idx(fft_idx), .special_vld(special_vld), .rd_en(rd_en),
        .rd_node_idx(rd_node_idx), .rd_succ_sel(rd_succ_sel), .rd_valid(rd_valid),
        .rd_next_idx(rd_next_idx), .rd_degree(rd_degree));

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // reference model: name dictionary in first-appearance order, successor lists per source
    int    m_cnt;
    int    m_idx[string];
    int    m_deg[64];
    int    m_succ[64][32];

    task automatic m_alloc(input string nm, output int idx);
        if (!m_idx.exists(nm)) begin
            m_idx[nm] = m_cnt;
            m_deg[m_cnt] = 0;
            m_cnt++;
        end
        idx = m_idx[nm];
    endtask

    task automatic model_line(input string ln);
        int s, d, k;
        if (ln.len() > 0) begin
            m_alloc(ln.substr(0, 2), s);
            k = 0;
            for (int p = 5; p + 2 < ln.len(); p += 4) begin
                m_alloc(ln.substr(p, p + 2), d);
                m_succ[s][k] = d;
                k++;
            end
            m_deg[s] = k;
        end
    endtask

    task automatic model_load(input string t);
        int st = 0;
        m_idx.delete();
        m_cnt = 0;
        for (int i = 0; i < t.len(); i++) begin
            if (t[i] == 8'h0a) begin
                model_line((i > st) ? t.substr(st, i - 1) : "");
                st = i + 1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int exp_low,
                             input bit gaps, input string tag);
        int lows = 0, w = 0;
        while (!in_ready && w < 16) begin w++; @(negedge clk); end
        if (!in_ready) chk({tag, "_ready_timeout"}, in_ready, 1);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_valid = 1'b1; in_byte = b; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        while (!in_ready && lows < 8) begin lows++; @(negedge clk); end
        if (exp_low >= 0) chk(tag, lows, exp_low);
    endtask

    // ready-low expectation: 2 after a 3rd name letter, 1 after a line-ending newline
    task automatic send_text(input string t, input bit gaps, input bit chk_rdy, input bit mark_last);
        int letters = 0, exp_low;
        bit last;
        logic [7:0] b;
        for (int i = 0; i < t.len(); i++) begin
            b = t[i];
            last = mark_last && (i == t.len() - 1);
            if (b >= 8'h61 && b <= 8'h7a) letters++; else letters = 0;
            exp_low = 0;
            if (letters == 3) begin exp_low = 2; letters = 0; end
            else if (b == 8'h0a && i > 0 && t[i-1] != 8'h0a) exp_low = 1;
            send_byte(b, last, (chk_rdy && !last) ? exp_low : -1, gaps,
                      $sformatf("ready_low_b%0d", i));
        end
    endtask

    int rq_n[$], rq_s[$], ex_n[$], ex_d[$];

    task automatic run_reads(input string tag);
        int n = rq_n.size();
        for (int i = 0; i <= n + 2; i++) begin
            chk($sformatf("%s_vld%0d", tag, i), rd_valid, (i >= 2 && i - 2 < n));
            if (i >= 2 && i - 2 < n) begin
                chk($sformatf("%s_next%0d", tag, i - 2), rd_next_idx, ex_n[i-2]);
                chk($sformatf("%s_deg%0d", tag, i - 2), rd_degree, ex_d[i-2]);
            end
            if (i < n) begin
                rd_en = 1'b1; rd_node_idx = rq_n[i]; rd_succ_sel = rq_s[i];
            end else rd_en = 1'b0;
            @(negedge clk);
        end
        rq_n.delete(); rq_s.delete(); ex_n.delete(); ex_d.delete();
    endtask

    function automatic string sp_name(int k);
        case (k)
            0: return "you";
            1: return "out";
            2: return "svr";
            3: return "dac";
            default: return "fft";
        endcase
    endfunction

    function automatic logic [NW-1:0] sp_obs(int k);
        case (k)
            0: return you_idx;
            1: return out_idx;
            2: return svr_idx;
            3: return dac_idx;
            default: return fft_idx;
        endcase
    endfunction

    task automatic check_load(input string tag);
        logic [4:0] ev = '0;
        chk({tag, "_done"}, load_done, 1);
        chk({tag, "_err"}, load_error, 0);
        chk({tag, "_count"}, node_count, m_cnt);
        for (int k = 0; k < 5; k++) begin
            ev[k] = m_idx.exists(sp_name(k));
            chk({tag, "_", sp_name(k)}, sp_obs(k), ev[k] ? m_idx[sp_name(k)] : 0);
        end
        chk({tag, "_spvld"}, special_vld, ev);
        for (int n = 0; n < m_cnt; n++)
            for (int s = 0; s <= m_deg[n]; s++) begin
                rq_n.push_back(n); rq_s.push_back(s);
                ex_n.push_back(s < m_deg[n] ? m_succ[n][s] : 0); ex_d.push_back(m_deg[n]);
            end
        run_reads({tag, "_rd"});
    endtask

    task automatic do_reset();
        rd_en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic string rname();
        return $sformatf("%c%c%c", 8'h61 + $urandom_range(0, 3), 8'h61 + $urandom_range(0, 3),
                         8'h61 + $urandom_range(0, 3));
    endfunction

    function automatic string wide_line(int n);
        string s = "zzz:";
        for (int k = 0; k < n; k++) s = {s, $sformatf(" b%c%c", 8'h61 + k / 26, 8'h61 + k % 26)};
        return {s, "\n"};
    endfunction

    string t1 = "aaa: you hhh\nyou: bbb ccc\nbbb: out\nccc: out\n";
    string t2 = "svr: dac\ndac: fft\nfft: out\n";
    string tr;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
        rd_en = 1'b0; rd_node_idx = '0; rd_succ_sel = '0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_error, 0);
        chk("rst_count", node_count, 0);
        chk("rst_spvld", special_vld, 0);
        chk("rst_you", you_idx, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_next", rd_next_idx, 0);
        chk("rst_rd_deg", rd_degree, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_in_ready", in_ready, 0);
        @(negedge clk);
        chk("src_in_ready", in_ready, 1);

        // example graph, no gaps, plus the fixed read sequence
        send_text(t1, 1'b0, 1'b1, 1'b1);
        chk("t1_count_const", node_count, 6);
        chk("t1_you_const", you_idx, 1);
        chk("t1_out_const", out_idx, 5);
        chk("t1_spvld_const", special_vld, 5'b00011);
        rq_n = '{1, 1, 5, 3}; rq_s = '{0, 1, 0, 0};
        ex_n = '{3, 4, 0, 5}; ex_d = '{2, 2, 0, 1};
        run_reads("t1_b2b");
        model_load(t1);
        check_load("t1");

        // same text with random in_valid gaps
        do_reset();
        send_text(t1, 1'b1, 1'b1, 1'b1);
        check_load("t1g");

        // bad character inside a name
        do_reset();
        send_text("aAa: bbb\n", 1'b0, 1'b0, 1'b1);
        chk("bad_err", load_error, 1);
        chk("bad_ready", in_ready, 1);
        chk("bad_done", load_done, 0);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bad_rd_valid%0d", i), rd_valid, 0);
        end
        rd_en = 1'b0;

        // out-degree limit
        do_reset();
        send_text(wide_line(32), 1'b0, 1'b0, 1'b1);
        chk("deg32_err", load_error, 1);
        chk("deg32_done", load_done, 0);
        do_reset();
        tr = wide_line(31);
        send_text(tr, 1'b0, 1'b1, 1'b1);
        model_load(tr);
        check_load("deg31");

        // reset while a read is in flight
        rd_en = 1'b1; rd_node_idx = '0; rd_succ_sel = 5'd3;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrd_valid", rd_valid, 0);
        chk("midrd_deg", rd_degree, 0);
        chk("midrd_next", rd_next_idx, 0);
        chk("midrd_done", load_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset in the middle of a load
        send_text("aaa: you", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midld_count", node_count, 0);
        chk("midld_you", you_idx, 0);
        chk("midld_spvld", special_vld, 0);
        chk("midld_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_text(t2, 1'b0, 1'b1, 1'b1);
        chk("t2_svr_const", svr_idx, 0);
        chk("t2_dac_const", dac_idx, 1);
        chk("t2_fft_const", fft_idx, 2);
        chk("t2_out_const", out_idx, 3);
        chk("t2_spvld_const", special_vld, 5'b11110);
        model_load(t2);
        check_load("t2");

        // random graphs over a small name alphabet (repeats and duplicate sources likely)
        for (int r = 0; r < 3; r++) begin
            tr = "";
            for (int l = 0; l < int'($urandom_range(1, 6)); l++) begin
                if ($urandom_range(0, 3) == 0) tr = {tr, "\n"};
                tr = {tr, rname(), ":"};
                for (int k = 0; k < int'($urandom_range(0, 4)); k++) tr = {tr, " ", rname()};
                tr = {tr, "\n"};
            end
            do_reset();
            send_text(tr, 1'b1, 1'b1, 1'b1);
            model_load(tr);
            check_load($sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/adjacency_loader.md
# adjacency_loader

Upstream stage of the path-counting core: accepts the puzzle text as a byte stream, assigns each distinct 3-letter node name a dense index in order of first appearance, and builds a compact adjacency store (per-node edge offset + out-degree, flat edge list). After loading, it serves successor lookups to the traversal core and publishes the indices of the special nodes (you, out, svr, dac, fft).

## Interface
- NODE_IDX_WIDTH, 10: node index width; max nodes 2^NODE_IDX_WIDTH.
- COUNTER_WIDTH, 5: out-degree width; max degree 2^COUNTER_WIDTH-1.
- EDGE_ADDR_WIDTH, 13: edge-list address width; max edges 2^EDGE_ADDR_WIDTH.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte present on in_byte.
- in_byte  in  8  ASCII input byte.
- in_last  in  1  qualifies the final byte of the input.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- load_done  out  1  adjacency store complete; sticky until reset.
- load_error  out  1  malformed input or capacity overflow; sticky until reset.
- node_count  out  NODE_IDX_WIDTH+1  number of allocated indices.
- you_idx, out_idx, svr_idx, dac_idx, fft_idx  out  NODE_IDX_WIDTH each  index of that name.
- special_vld  out  5  per-name valid {fft,dac,svr,out,you}.
- rd_en  in  1  lookup request.
- rd_node_idx  in  NODE_IDX_WIDTH  source node.
- rd_succ_sel  in  COUNTER_WIDTH  successor ordinal (0-based).
- rd_valid  out  1  response strobe.
- rd_next_idx  out  NODE_IDX_WIDTH  selected successor index.
- rd_degree  out  COUNTER_WIDTH  out-degree of rd_node_idx.

## Operation
- Name key: 15 bits, {c0-'a', c1-'a', c2-'a'} at 5 bits each. Any character outside 'a'..'z' inside a name raises load_error.
- Lookup: name_map[key] yields candidate idx; hit iff idx < node_count and rev_name[idx] == key. No table clear is needed; reset zeroes node_count only.
- Miss: allocate idx = node_count, write name_map, rev_name, degree[idx]=0; node_count++. Allocation at node_count == 2^NODE_IDX_WIDTH -> load_error.
- Line grammar: NAME ':' (' ' NAME)* '\n'. in_last on any byte also terminates the current line.
- FSM: IDLE -> SRC (3 chars) -> LOOKUP -> WRITE -> COLON -> SEP; SEP on ' ' -> DST (3 chars) -> LOOKUP -> WRITE -> SEP; SEP on '\n' -> FINAL -> SRC; in_last -> FINAL -> DONE.
  - WRITE (src): latch src idx, line_start = edge_ptr, cnt = 0.
  - WRITE (dst): edge[edge_ptr] = dst idx; edge_ptr++, cnt++.
  - FINAL: offset[src] = line_start, degree[src] = cnt.
- '\n' in SRC with 0 chars collected (blank line) is skipped. Any other unexpected byte -> ERROR.
- cnt reaching 2^COUNTER_WIDTH or edge_ptr wrap -> ERROR.
- Duplicate source line: the later line overwrites offset/degree; earlier edges are orphaned.
- Special names are compared at every allocation; matching sets the idx and valid bit.
- ERROR: load_error=1, in_ready=1 (stream drained and discarded), load_done stays 0.
- Reads: rd_en is honoured only when load_done=1; otherwise rd_valid stays 0. rd_succ_sel >= degree returns rd_next_idx = 0 with the correct rd_degree.

## Timing
- Reset values: in_ready=0, load_done=0, load_error=0, node_count=0, all *_idx=0, special_vld=0, rd_valid=0, rd_next_idx=0, rd_degree=0; FSM=IDLE.
- IDLE -> SRC one cycle after reset release. in_ready=1 in SRC, COLON, SEP, DST.
- in_ready=0 for exactly 2 cycles (LOOKUP, WRITE) after each accepted third name character, and for 1 cycle in FINAL.
- load_done rises the cycle after FINAL of the in_last line.
- Read pipeline, 2-cycle latency, one request per cycle, no stall:
  - stage 1 reads offset/degree;
  - stage 2 reads edge[offset + rd_succ_sel].
  - rd_valid asserts 2 cycles after rd_en.
- Reset asserted mid-load or mid-read: all outputs return to reset values asynchronously; in-flight reads are dropped.

## Test plan
- Load "aaa: you hhh\nyou: bbb ccc\nbbb: out\nccc: out\n" (in_last on the final '\n'). Require aaa=0, you=1, hhh=2, bbb=3, ccc=4, out=5; node_count=6; you_idx=1, out_idx=5, special_vld=5'b00011; load_done.
- After the load above, back-to-back reads (1,0), (1,1), (5,0), (3,0). Require rd_valid on cycles +2..+5 with (3,2), (4,2), (0,0), (5,1) as (next, degree).
- Random in_valid gaps during the load above. Require in_ready low exactly 2 cycles after each name and 1 after each newline, and identical tables.
- "aAa: bbb\n". Require load_error=1, in_ready=1, load_done=0, rd_valid never set.
- One source line with 32 successors. Require load_error. The same line with 31 successors loads with degree 31.
- Reset mid-load, then load "svr: dac\ndac: fft\nfft: out\n". Require svr=0, dac=1, fft=2, out=3; special_vld=5'b11110.
